// File: rtl/halli_galli_pkg.sv
// Shared types and helpers for the Halli Galli round controller and its arbiter.
package halli_galli_pkg;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        RESOLVE = 2'd1,
        OVER    = 2'd2
    } state_t;

    // Colour codes as decoded by the full-colour LED driver
    localparam logic [2:0] COLOR_RED    = 3'd0;
    localparam logic [2:0] COLOR_GREEN  = 3'd1;
    localparam logic [2:0] COLOR_YELLOW = 3'd2;
    localparam logic [2:0] COLOR_PURPLE = 3'd3;
    localparam logic [2:0] COLOR_BLUE   = 3'd4;
    localparam logic [2:0] COLOR_ORANGE = 3'd5;
    localparam logic [2:0] COLOR_PINK   = 3'd6;
    localparam logic [2:0] COLOR_WHITE  = 3'd7;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Cards are packed as {colour, number}; callers zero-extend into 16 bits.
    function automatic logic [7:0] card_number(input logic [15:0] card, input int num_w);
        logic [15:0] mask;
        mask = (16'd1 << num_w) - 16'd1;
        return 8'(card & mask);
    endfunction

    function automatic logic [7:0] card_colour(input logic [15:0] card, input int num_w,
                                               input int col_w);
        logic [15:0] mask;
        mask = (16'd1 << col_w) - 16'd1;
        return 8'((card >> num_w) & mask);
    endfunction

endpackage

// File: rtl/hg_rr_arbiter.sv
// Rotating-priority arbiter: the search starts one position after the pointer.
module hg_rr_arbiter
    import halli_galli_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(pointer) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/halli_galli_round_ctrl.sv
// N-player Halli Galli round controller: turns, face-up cards, bell check,
// ring arbitration, scoring and end-of-game detection.
module halli_galli_round_ctrl
    import halli_galli_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int NUM_COLORS  = 4,
    parameter int NUM_W       = 3,
    parameter int TARGET      = 5,
    parameter int PENALTY     = 2,
    parameter int MAX_FLIPS   = 40,
    parameter int GRACE_CYC   = 1000,
    parameter int SCORE_W     = 8,
    localparam int CLW = clog2(NUM_COLORS),
    localparam int CW  = CLW + NUM_W,
    localparam int PW  = clog2(NUM_PLAYERS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flip_req,
    input  logic [CW-1:0]                  card_in,
    input  logic [NUM_PLAYERS-1:0]         bell,
    output logic [PW-1:0]                  turn,
    output logic [NUM_PLAYERS*CLW-1:0]     face_color,
    output logic [NUM_PLAYERS*NUM_W-1:0]   face_num,
    output logic                           bell_ok,
    output logic                           ring_valid,
    output logic [PW-1:0]                  ring_who,
    output logic                           ring_right,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           game_over,
    output logic [PW-1:0]                  winner
);

    localparam int SW   = clog2(NUM_PLAYERS * (2**NUM_W - 1) + 1);
    localparam int FCW  = clog2(NUM_PLAYERS + 1);
    localparam int FW   = clog2(MAX_FLIPS + 1);
    localparam int GW   = clog2(GRACE_CYC + 1);
    localparam int SCW1 = SCORE_W + 1;

    state_t               state_reg, state_next;
    logic [PW-1:0]        turn_reg, turn_next;
    logic [CLW-1:0]       color_reg [NUM_PLAYERS];
    logic [CLW-1:0]       color_next [NUM_PLAYERS];
    logic [NUM_W-1:0]     num_reg [NUM_PLAYERS];
    logic [NUM_W-1:0]     num_next [NUM_PLAYERS];
    logic [SCORE_W-1:0]   score_reg [NUM_PLAYERS];
    logic [SCORE_W-1:0]   score_next [NUM_PLAYERS];
    logic [FW-1:0]        flips_reg, flips_next;
    logic [GW-1:0]        grace_reg, grace_next;
    logic [PW-1:0]        ptr_reg, ptr_next;
    logic                 ring_valid_reg, ring_valid_next;
    logic [PW-1:0]        ring_who_reg, ring_who_next;
    logic                 ring_right_reg, ring_right_next;
    logic                 game_over_reg, game_over_next;
    logic [PW-1:0]        winner_reg, winner_next;

    logic [NUM_W-1:0]       num_in;
    logic [CLW-1:0]         color_in;
    logic [NUM_COLORS-1:0]  color_hit;
    logic [FCW-1:0]         face_cnt;
    logic [SCW1-1:0]        score_sum;
    logic [PW-1:0]          best_idx;
    logic [SCORE_W-1:0]     best_score;
    logic [NUM_PLAYERS-1:0] grant;
    logic [PW-1:0]          grant_idx;
    logic                   bell_any;
    logic                   ring_req;

    assign num_in   = NUM_W'(card_number(16'(card_in), NUM_W));
    assign color_in = CLW'(card_colour(16'(card_in), NUM_W, CLW));

    hg_rr_arbiter #(.N(NUM_PLAYERS)) u_arb (
        .req       (bell),
        .pointer   (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (bell_any)
    );

    assign ring_req = bell_any & (|grant);

    // Per-colour fruit sums over non-empty faces, taken from the registered cards
    generate
        for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_color
            logic [SW-1:0] sum;
            always_comb begin
                sum = '0;
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (num_reg[p] != '0 && color_reg[p] == CLW'(gi))
                        sum = sum + SW'(num_reg[p]);
                end
            end
            assign color_hit[gi] = (sum == SW'(TARGET));
        end
    endgenerate

    assign bell_ok = |color_hit;

    always_comb begin
        face_cnt = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (num_reg[p] != '0) face_cnt = face_cnt + FCW'(1);
    end

    always_comb begin
        score_next = score_reg;
        score_sum  = {1'b0, score_reg[ring_who_reg]} + SCW1'(face_cnt);
        if (state_reg == RESOLVE) begin
            if (ring_right_reg)
                score_next[ring_who_reg] = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            else if (score_reg[ring_who_reg] > SCORE_W'(PENALTY))
                score_next[ring_who_reg] = score_reg[ring_who_reg] - SCORE_W'(PENALTY);
            else
                score_next[ring_who_reg] = '0;
        end
    end

    // Winner looks at post-ring scores so a last-moment ring counts
    always_comb begin
        best_idx   = '0;
        best_score = score_next[0];
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            if (score_next[p] > best_score) begin
                best_score = score_next[p];
                best_idx   = PW'(p);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        turn_next       = turn_reg;
        color_next      = color_reg;
        num_next        = num_reg;
        flips_next      = flips_reg;
        grace_next      = grace_reg;
        ptr_next        = ptr_reg;
        ring_valid_next = 1'b0;
        ring_who_next   = ring_who_reg;
        ring_right_next = ring_right_reg;
        game_over_next  = game_over_reg;
        winner_next     = winner_reg;
        case (state_reg)
            PLAY: begin
                if (flips_reg == FW'(MAX_FLIPS))
                    grace_next = grace_reg + GW'(1);
                if (ring_req) begin
                    state_next      = RESOLVE;
                    ring_valid_next = 1'b1;
                    ring_who_next   = grant_idx;
                    ring_right_next = bell_ok;
                end else begin
                    if (flip_req && flips_reg < FW'(MAX_FLIPS) && num_in != '0) begin
                        color_next[turn_reg] = color_in;
                        num_next[turn_reg]   = num_in;
                        turn_next  = (turn_reg == PW'(NUM_PLAYERS - 1)) ? '0 : turn_reg + PW'(1);
                        flips_next = flips_reg + FW'(1);
                    end
                    if (grace_next >= GW'(GRACE_CYC)) begin
                        state_next     = OVER;
                        game_over_next = 1'b1;
                        winner_next    = best_idx;
                    end
                end
            end
            RESOLVE: begin
                ptr_next = ring_who_reg;
                if (ring_right_reg) begin
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        color_next[p] = '0;
                        num_next[p]   = '0;
                    end
                end
                if (grace_reg >= GW'(GRACE_CYC)) begin
                    state_next     = OVER;
                    game_over_next = 1'b1;
                    winner_next    = best_idx;
                end else begin
                    state_next = PLAY;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= PLAY;
            turn_reg       <= '0;
            flips_reg      <= '0;
            grace_reg      <= '0;
            ptr_reg        <= '0;
            ring_valid_reg <= 1'b0;
            ring_who_reg   <= '0;
            ring_right_reg <= 1'b0;
            game_over_reg  <= 1'b0;
            winner_reg     <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                color_reg[p] <= '0;
                num_reg[p]   <= '0;
                score_reg[p] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            turn_reg       <= turn_next;
            flips_reg      <= flips_next;
            grace_reg      <= grace_next;
            ptr_reg        <= ptr_next;
            ring_valid_reg <= ring_valid_next;
            ring_who_reg   <= ring_who_next;
            ring_right_reg <= ring_right_next;
            game_over_reg  <= game_over_next;
            winner_reg     <= winner_next;
            color_reg      <= color_next;
            num_reg        <= num_next;
            score_reg      <= score_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_out
            assign face_color[gi*CLW +: CLW]         = color_reg[gi];
            assign face_num[gi*NUM_W +: NUM_W]       = num_reg[gi];
            assign score[gi*SCORE_W +: SCORE_W]      = score_reg[gi];
        end
    endgenerate

    assign turn       = turn_reg;
    assign ring_valid = ring_valid_reg;
    assign ring_who   = ring_who_reg;
    assign ring_right = ring_right_reg;
    assign game_over  = game_over_reg;
    assign winner     = winner_reg;

endmodule

// File: tb/tb_halli_galli_round_ctrl.sv
// Randomised bench for halli_galli_round_ctrl: game-level reference model plus ring scoreboard.
module tb_halli_galli_round_ctrl;

    localparam int NP    = 4;
    localparam int NC    = 4;
    localparam int NW    = 3;
    localparam int TGT   = 5;
    localparam int PEN   = 2;
    localparam int MAXF  = 40;
    localparam int GRACE = 8;
    localparam int SCW   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flip_req = 1'b0;
    logic [4:0]  card_in = '0;
    logic [3:0]  bell = '0;
    logic [1:0]  turn;
    logic [7:0]  face_color;
    logic [11:0] face_num;
    logic        bell_ok;
    logic        ring_valid;
    logic [1:0]  ring_who;
    logic        ring_right;
    logic [31:0] score;
    logic        game_over;
    logic [1:0]  winner;

    halli_galli_round_ctrl #(
        .NUM_PLAYERS(NP), .NUM_COLORS(NC), .NUM_W(NW), .TARGET(TGT), .PENALTY(PEN),
        .MAX_FLIPS(MAXF), .GRACE_CYC(GRACE), .SCORE_W(SCW)
    ) dut (
        .clk(clk), .rst(rst), .flip_req(flip_req), .card_in(card_in), .bell(bell),
        .turn(turn), .face_color(face_color), .face_num(face_num), .bell_ok(bell_ok),
        .ring_valid(ring_valid), .ring_who(ring_who), .ring_right(ring_right),
        .score(score), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int who;
        int right;
    } ring_t;
    ring_t exp_q[$];
    ring_t e_mon;

    // Game state as the rules describe it
    int m_col[NP];
    int m_num[NP];
    int m_score[NP];
    int m_turn, m_flips, m_grace, m_ptr, m_winner;
    bit m_over;

    int r, rc, rn, rb;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_bell_ok();
        int s;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int p = 0; p < NP; p++)
                if (m_num[p] != 0 && m_col[p] == c) s += m_num[p];
            if (s == TGT) return 1;
        end
        return 0;
    endfunction

    function automatic int model_winner();
        int best = 0;
        for (int p = 1; p < NP; p++)
            if (m_score[p] > m_score[best]) best = p;
        return best;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_col[p] = 0; m_num[p] = 0; m_score[p] = 0;
        end
        m_turn = 0; m_flips = 0; m_grace = 0; m_ptr = 0; m_winner = 0; m_over = 0;
    endtask

    task automatic check_state(input string tag);
        chk($sformatf("%s turn", tag), int'(turn), m_turn);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s face_num[%0d]", tag, p), int'(face_num[p*NW +: NW]), m_num[p]);
            chk($sformatf("%s face_color[%0d]", tag, p), int'(face_color[p*2 +: 2]), m_col[p]);
            chk($sformatf("%s score[%0d]", tag, p), int'(score[p*SCW +: SCW]), m_score[p]);
        end
        chk($sformatf("%s bell_ok", tag), int'(bell_ok), model_bell_ok());
        chk($sformatf("%s ring_valid", tag), int'(ring_valid), 0);
        chk($sformatf("%s game_over", tag), int'(game_over), int'(m_over));
        if (m_over) chk($sformatf("%s winner", tag), int'(winner), m_winner);
    endtask

    // One PLAY cycle of stimulus (plus the RESOLVE cycle if a bell is granted)
    task automatic cycle(input string tag, input bit f, input int col, input int num, input int b);
        int who;
        int rt;
        int cnt;
        bit rang;
        flip_req = f;
        card_in  = {col[1:0], num[2:0]};
        bell     = b[3:0];
        rang = 0;
        who  = 0;
        rt   = 0;
        if (!m_over) begin
            if (m_flips == MAXF) m_grace++;
            if (b[3:0] != 0) begin
                for (int k = NP; k >= 1; k--)
                    if (b[(m_ptr + k) % NP]) who = (m_ptr + k) % NP;
                rt = model_bell_ok();
                exp_q.push_back('{who, rt});
                rang = 1;
            end else if (f && m_flips < MAXF && num != 0) begin
                m_col[m_turn] = col;
                m_num[m_turn] = num;
                m_turn = (m_turn + 1) % NP;
                m_flips++;
            end
        end
        @(negedge clk);
        flip_req = 1'b0;
        bell     = '0;
        if (rang) begin
            @(negedge clk);
            if (rt != 0) begin
                cnt = 0;
                for (int p = 0; p < NP; p++) if (m_num[p] != 0) cnt++;
                m_score[who] = (m_score[who] + cnt > 255) ? 255 : m_score[who] + cnt;
                for (int p = 0; p < NP; p++) begin
                    m_num[p] = 0; m_col[p] = 0;
                end
            end else begin
                m_score[who] = (m_score[who] > PEN) ? m_score[who] - PEN : 0;
            end
            m_ptr = who;
        end
        if (!m_over && m_grace >= GRACE) begin
            m_over   = 1;
            m_winner = model_winner();
        end
        check_state(tag);
    endtask

    // Reset asserted mid-cycle; its effect must be visible before any clock edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state(tag);
        chk($sformatf("%s ring_who", tag), int'(ring_who), 0);
        chk($sformatf("%s ring_right", tag), int'(ring_right), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ring_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ring_unexpected: got ring from %0d expected no ring", ring_who);
            end else begin
                e_mon = exp_q.pop_front();
                chk("ring_who", int'(ring_who), e_mon.who);
                chk("ring_right", int'(ring_right), e_mon.right);
                $display("ring: who=%0d right=%0d", ring_who, ring_right);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        check_state("por");
        chk("por ring_who", int'(ring_who), 0);
        chk("por ring_right", int'(ring_right), 0);
        rst = 1'b0;

        // Game A: directed openings, then random play to the end
        cycle("flip1", 1, 0, 2, 0);
        cycle("flip2", 1, 1, 4, 0);
        cycle("flip3", 1, 0, 3, 0);
        cycle("ring_right", 0, 0, 0, 4'b0100);
        cycle("flip4", 1, 2, 5, 0);
        cycle("ring_single", 0, 0, 0, 4'b0010);
        cycle("flip5", 1, 0, 1, 0);
        cycle("flip6", 1, 1, 1, 0);
        cycle("ring_wrong", 0, 0, 0, 4'b0010);
        cycle("rot1", 0, 0, 0, 4'b1010);
        cycle("rot2", 0, 0, 0, 4'b1010);
        cycle("flip_with_bell", 1, 3, 2, 4'b0001);
        cycle("zero_card", 1, 2, 0, 0);

        for (int n = 0; n < 3000 && !m_over; n++) begin
            r  = $urandom_range(0, 99);
            rc = $urandom_range(0, NC - 1);
            rn = $urandom_range(0, 7);
            rb = $urandom_range(1, 15);
            if (r < 15)      cycle("rand_bell", r[0], rc, rn, rb);
            else if (r < 90) cycle("rand_flip", 1, rc, rn, 0);
            else             cycle("rand_idle", 0, 0, 0, 0);
        end
        chk("gameA over reached", int'(game_over), 1);
        for (int n = 0; n < 5; n++)
            cycle("after_over", 1, $urandom_range(0, NC - 1), $urandom_range(1, 7), $urandom_range(1, 15));

        // Game B: bell in the last grace cycle resolves before the game ends
        do_reset("reset_gameB");
        for (int n = 0; n < MAXF; n++)
            cycle("gB_flip", 1, $urandom_range(0, NC - 1), $urandom_range(1, 7), 0);
        cycle("gB_extra_flip", 1, 1, 3, 0);
        for (int n = 0; n < GRACE - 2; n++)
            cycle("gB_grace", 0, 0, 0, 0);
        cycle("gB_last_bell", 0, 0, 0, $urandom_range(1, 15));
        chk("gB over", int'(game_over), 1);
        cycle("gB_ignored", 1, 2, 4, 4'b1111);

        // Reset while a ring is being resolved: no score change, no pulse
        do_reset("reset_gameC");
        cycle("gC_flip", 1, 1, 5, 0);
        bell = 4'b0001;
        @(posedge clk);
        #2 rst = 1'b1;
        bell = '0;
        #1;
        model_reset();
        check_state("rst_in_resolve");
        @(negedge clk);
        rst = 1'b0;
        cycle("gC_idle", 0, 0, 0, 0);
        cycle("gC_idle2", 0, 0, 0, 0);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
